branch_predictor_bht: RTL
=========================

# branch_predictor_bht

Parametrised branch direction predictor for the 5-stage RISC-V 151 pipeline, replacing the single-bit predictor. It sits beside the ID stage and returns a taken/not-taken prediction for each B-type instruction. The index is carried down the pipe, and the table is trained when the branch resolves in EX. It supports bimodal mode (GHR_BITS=0) and gshare mode (GHR_BITS>0), and keeps performance counters readable through CSR logic.

## Interface
- ENTRIES, 64: number of table entries; power of two, 4..1024; IDX_W = log2(ENTRIES).
- CTR_BITS, 2: width of each saturating counter; 1..4.
- GHR_BITS, 0: global history length; 0 selects bimodal; must be ≤ IDX_W.
- INDEX_LSB, 2: lowest PC bit used for indexing.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline freeze; blocks table, GHR and counter updates.
- lookup_valid  in  1  ID holds a B-type instruction (btype_ID).
- lookup_pc  in  32  PC of the ID instruction.
- predict_taken  out  1  prediction; 0 when lookup_valid=0.
- predict_index  out  IDX_W  index used for the lookup; pipelined to EX by the core.
- update_valid  in  1  a B-type instruction resolves in EX this cycle.
- update_index  in  IDX_W  predict_index carried with that instruction.
- update_taken  in  1  actual outcome (branch_result_EX).
- update_mispredict  in  1  prediction was wrong.
- lookup_count  out  32  number of lookups accepted.
- mispredict_count  out  32  number of mispredicts accepted.

## Operation
- Index in bimodal mode: lookup_pc[INDEX_LSB +: IDX_W].
- Index in gshare mode: the same PC field XOR {zeros, ghr}.
- Prediction: predict_taken = lookup_valid & ctr[index][CTR_BITS-1] (counter MSB).
- Training on an accepted update (update_valid & ~stall):
  - taken: counter increments, saturating at 2^CTR_BITS-1.
  - not taken: counter decrements, saturating at 0.
- GHR:
  - On an accepted update: ghr <= {ghr[GHR_BITS-2:0], update_taken}.
  - Updated at resolve only; no speculative history, no repair.
  - With GHR_BITS=1 it is a single bit.
- Bypass: when an accepted update hits the same index as the current lookup, the prediction uses the post-update counter value. In gshare mode the lookup index uses the pre-update GHR.
- Performance counters:
  - lookup_count increments on lookup_valid & ~stall.
  - mispredict_count increments on update_valid & update_mispredict & ~stall.
  - Both saturate at 32'hFFFF_FFFF and do not wrap.
- update_mispredict with update_valid=0 is ignored.
- Reset values:
  - Every counter is weakly-not-taken, 2^(CTR_BITS-1)-1; with CTR_BITS=1 this is 0.
  - ghr = 0; lookup_count = 0; mispredict_count = 0.
  - predict_index follows its combinational inputs; predict_taken = 0 while lookup_valid=0.
- Reset asserted mid-operation takes priority over every update in the same cycle.

## Timing
- Lookup is combinational, lookup_pc/lookup_valid to predict_taken/predict_index, within the ID cycle.
- The table, GHR and performance counters update on the posedge after an accepted update. They are visible to lookups in the next cycle, or in the same cycle through the bypass.
- Stall held for N cycles: the state is frozen, and outputs track the held inputs combinationally.
- Update-to-use latency is 0 with the bypass and 1 cycle without it.
- Table storage is flip-flops (no SRAM), so reset completes in one cycle.

## Structure
- Package bp_pkg holds:
  - constant function clog2;
  - function ctr_init(CTR_BITS);
  - function sat_inc / sat_dec on a CTR_BITS-wide value.
- Sub-module bht_sat_ctr: one counter entry with clk, reset, en, taken and a ctr output. It is instantiated ENTRIES times in a generate loop, with en = accepted update & (update_index == i).
- Top level holds the index hash, the GHR shift register, the bypass mux and the performance counters.

## Test plan
- Reset, then a lookup at PC 0x0000_2000 with default parameters → predict_taken=0, predict_index=0x00; ctr[0]=2'b01; both counts=0.
- Two taken updates to index 5, then a lookup of PC 0x14 → predict_taken=1; a further three taken updates leave ctr[5]=2'b11 (saturated); a following not-taken update gives 2'b10, still predicted taken.
- Same-cycle update (index 7, taken, from 2'b01) and lookup of PC 0x1C → predict_taken=1 that same cycle (bypass).
- GHR_BITS=4, updates with outcomes T,T,N,T → ghr=4'b1101; a lookup of PC 0x0 → predict_index=0x0D.
- Stall held high for 3 cycles with update_valid and lookup_valid both high → table, GHR and counts unchanged; after stall falls, one update → mispredict_count increments by exactly 1.
- Preload mispredict_count=32'hFFFF_FFFE through a test force, then 3 mispredicts → the count stays at 32'hFFFF_FFFF. Reset asserted together with an update → every counter returns to its reset value.

Source files
------------

// File: rtl/branch_predictor_bht_pkg.sv
// bp_pkg: shared helpers for the branch history table predictor.
//   clog2     - constant log2 (ceiling) used to size the table index
//   ctr_init  - weakly-not-taken reset value for a counter of a given width
//   sat_inc   - saturating increment of a counter of a given width
//   sat_dec   - saturating decrement (floors at zero)
// Counter values travel through these helpers zero-extended to CTR_W_MAX
// bits so that one function body serves every counter width from 1 to 4.
package bp_pkg;

  localparam int CTR_W_MAX = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic logic [CTR_W_MAX-1:0] ctr_init(input int bits);
    return CTR_W_MAX'((1 << (bits - 1)) - 1);
  endfunction

  function automatic logic [CTR_W_MAX-1:0] sat_inc(input logic [CTR_W_MAX-1:0] value,
                                                   input int bits);
    logic [CTR_W_MAX-1:0] max_val;
    max_val = CTR_W_MAX'((1 << bits) - 1);
    return (value == max_val) ? value : value + 1'b1;
  endfunction

  function automatic logic [CTR_W_MAX-1:0] sat_dec(input logic [CTR_W_MAX-1:0] value,
                                                   input int bits);
    return (value == '0) ? value : value - 1'b1;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// branch_predictor_bht_if: lookup, training and statistics signals between
// the pipeline (master) and the predictor (slave).
//   lookup_valid/lookup_pc        - ID-stage B-type instruction and its PC
//   predict_taken/predict_index   - combinational prediction and table index
//   update_valid/index/taken/mispredict - branch resolution from EX
//   lookup_count/mispredict_count - saturating performance counters
interface branch_predictor_bht_if #(
  parameter int IDX_W = 6
);
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             predict_taken;
  logic [IDX_W-1:0] predict_index;
  logic             update_valid;
  logic [IDX_W-1:0] update_index;
  logic             update_taken;
  logic             update_mispredict;
  logic [31:0]      lookup_count;
  logic [31:0]      mispredict_count;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_index, update_taken, update_mispredict,
    input  predict_taken, predict_index,
    input  lookup_count, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_index, update_taken, update_mispredict,
    output predict_taken, predict_index,
    output lookup_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_bht_sat_ctr.sv
// bht_sat_ctr: one saturating direction counter of the history table.
//   clk, reset - clock and synchronous active-high reset
//   en         - train this entry on the coming edge
//   taken      - resolved direction (1 counts up, 0 counts down)
//   ctr        - current counter value; MSB is the predicted direction
module bht_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                taken,
  output logic [CTR_BITS-1:0] ctr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr <= CTR_BITS'(ctr_init(CTR_BITS));
    end else if (en) begin
      if (taken) ctr <= CTR_BITS'(sat_inc(CTR_W_MAX'(ctr), CTR_BITS));
      else       ctr <= CTR_BITS'(sat_dec(CTR_W_MAX'(ctr), CTR_BITS));
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: bimodal (GHR_BITS=0) or gshare (GHR_BITS>0) branch
// direction predictor built from a flip-flop table of saturating counters.
//   clk, reset - clock and synchronous active-high reset
//   stall      - freezes table, history and performance counters
//   bus        - slave side of branch_predictor_bht_if (lookup, training,
//                prediction and performance counters)
// The interface instance must be built with IDX_W = clog2(ENTRIES).
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 0,
  parameter int INDEX_LSB = 2
) (
  input logic clk,
  input logic reset,
  input logic stall,
  branch_predictor_bht_if.slave bus
);

  localparam int IDX_W = clog2(ENTRIES);

  logic [CTR_BITS-1:0] ctr_tbl [ENTRIES];
  logic [IDX_W-1:0]    hist_mix;
  logic [IDX_W-1:0]    lookup_index;
  logic                accept_update;
  logic [CTR_BITS-1:0] ctr_sel;
  logic [CTR_BITS-1:0] ctr_trained;
  logic [CTR_BITS-1:0] ctr_effective;
  logic [31:0]         lookup_q;
  logic [31:0]         mispredict_q;
  logic                unused_pc_bits;

  assign accept_update  = bus.update_valid & ~stall;
  assign unused_pc_bits = ^bus.lookup_pc;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bht_sat_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .en    (accept_update && (bus.update_index == IDX_W'(i))),
      .taken (bus.update_taken),
      .ctr   (ctr_tbl[i])
    );
  end

  // History only advances when a branch resolves, so the lookup always hashes
  // with the history as it stood before any update in the same cycle.
  if (GHR_BITS > 0) begin : g_gshare
    logic [GHR_BITS-1:0] ghr;

    always_ff @(posedge clk) begin
      if (reset)              ghr <= '0;
      else if (accept_update) ghr <= (ghr << 1) | GHR_BITS'(bus.update_taken);
    end

    assign hist_mix = IDX_W'(ghr);
  end else begin : g_bimodal
    assign hist_mix = '0;
  end

  assign lookup_index      = bus.lookup_pc[INDEX_LSB +: IDX_W] ^ hist_mix;
  assign bus.predict_index = lookup_index;

  // Bypass: a training write to the entry being looked up is forwarded so the
  // prediction already reflects this cycle's resolved outcome.
  always_comb begin
    ctr_sel = ctr_tbl[lookup_index];
    if (bus.update_taken) ctr_trained = CTR_BITS'(sat_inc(CTR_W_MAX'(ctr_sel), CTR_BITS));
    else                  ctr_trained = CTR_BITS'(sat_dec(CTR_W_MAX'(ctr_sel), CTR_BITS));
    ctr_effective = ctr_sel;
    if (accept_update && (bus.update_index == lookup_index)) ctr_effective = ctr_trained;
  end

  assign bus.predict_taken = bus.lookup_valid & ctr_effective[CTR_BITS-1];

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      lookup_q     <= '0;
      mispredict_q <= '0;
    end else begin
      if (bus.lookup_valid && !stall && (lookup_q != '1))
        lookup_q <= lookup_q + 32'd1;
      if (accept_update && bus.update_mispredict && (mispredict_q != '1))
        mispredict_q <= mispredict_q + 32'd1;
    end
  end

  assign bus.lookup_count     = lookup_q;
  assign bus.mispredict_count = mispredict_q;

endmodule
